// File: rtl/seven_seg_capture.sv
// seven_seg_capture: debounce and decode a seven-segment bus into hex digits (optional fib check: SEVEN_SEG_FIB_CHECK_EN)
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] sevenSeg,
  input  logic       fib,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       locked,
  output logic       seg_err,
  output logic [7:0] digit_count,
  output logic       fib_err
);
  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
  state_t state;
  logic [6:0] p, seg_q;
  logic [7:0] cnt;
  logic       legal, last_edge;
  logic [3:0] val;
`ifdef SEVEN_SEG_FIB_CHECK_EN
  logic fib_q, fib_exp;
  always_comb fib_exp = val inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'hd};
`else
  logic fib_unused;
  assign fib_unused = fib;
`endif
  always_comb begin
    p = ACTIVE_LOW ? ~sevenSeg : sevenSeg;
    last_edge = cnt == 8'(STABLE_CYCLES - 2);
    legal = 1'b1;
    val = 4'h0;
    case (seg_q)
      7'h3F: val = 4'h0;
      7'h06: val = 4'h1;
      7'h5B: val = 4'h2;
      7'h4F: val = 4'h3;
      7'h66: val = 4'h4;
      7'h6D: val = 4'h5;
      7'h7D: val = 4'h6;
      7'h07: val = 4'h7;
      7'h7F: val = 4'h8;
      7'h6F: val = 4'h9;
      7'h77: val = 4'hA;
      7'h7C: val = 4'hB;
      7'h39: val = 4'hC;
      7'h5E: val = 4'hD;
      7'h79: val = 4'hE;
      7'h71: val = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      seg_q <= 7'h00;
      cnt <= 8'd0;
      digit <= 4'h0;
      digit_valid <= 1'b0;
      locked <= 1'b0;
      seg_err <= 1'b0;
      digit_count <= 8'd0;
      fib_err <= 1'b0;
`ifdef SEVEN_SEG_FIB_CHECK_EN
      fib_q <= 1'b0;
`endif
    end else begin
      digit_valid <= 1'b0;
      seg_err <= 1'b0;
      fib_err <= 1'b0;
      if (p != seg_q) begin
        seg_q <= p;
        cnt <= 8'd0;
        state <= SETTLE;
        locked <= 1'b0;
`ifdef SEVEN_SEG_FIB_CHECK_EN
        fib_q <= fib;
`endif
      end else if (state == SETTLE && !last_edge) begin
        cnt <= cnt + 8'd1;
      end else if (state == SETTLE && seg_q == 7'h00) begin
        state <= IDLE;
      end else if (state == SETTLE && !legal) begin
        seg_err <= 1'b1;
        state <= IDLE;
      end else if (state == SETTLE) begin
        digit <= val;
        digit_valid <= 1'b1;
        locked <= 1'b1;
        digit_count <= digit_count + 8'd1;
        state <= LOCKED;
`ifdef SEVEN_SEG_FIB_CHECK_EN
        fib_err <= fib_q != fib_exp;
`endif
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: randomized self-checking bench for seven_seg_capture against a run-length reference model
module tb_seven_seg_capture;
  localparam int S = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] sevenSeg = 7'h00;
  logic       fib = 1'b0;
  logic [3:0] digit;
  logic       digit_valid, locked, seg_err, fib_err;
  logic [7:0] digit_count;
  logic [15:0] out_vec, exp_vec;
  int vecs = 0;
  int fails = 0;
  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] m_last;
  int         m_run;
  logic [3:0] m_digit;
  logic [7:0] m_count;
  logic       m_locked, m_dv, m_se, m_fe, m_fib;
  seven_seg_capture #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .sevenSeg(sevenSeg), .fib(fib),
    .digit(digit), .digit_valid(digit_valid), .locked(locked),
    .seg_err(seg_err), .digit_count(digit_count), .fib_err(fib_err)
  );
  always #5 clk = ~clk;
  assign out_vec = {digit, digit_valid, locked, seg_err, digit_count, fib_err};
  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (codes[i] == p) return i;
    return -1;
  endfunction
  function automatic logic [6:0] bus_of(input int d);
    return ~codes[d];
  endfunction
  task automatic step(input logic [6:0] bus, input logic f, input logic rst_n);
    logic [6:0] p;
    int d;
    sevenSeg = bus;
    fib = f;
    reset = rst_n;
    @(posedge clk);
    #1;
    m_dv = 0;
    m_se = 0;
    m_fe = 0;
    if (!rst_n) begin
      m_last = 7'h00;
      m_run = 1000;
      m_digit = 0;
      m_count = 0;
      m_locked = 0;
      m_fib = 0;
    end else begin
      p = ~bus;
      if (p != m_last) begin
        m_last = p;
        m_run = 1;
        m_fib = f;
        m_locked = 0;
      end else m_run++;
      if (m_run == S && p != 7'h00) begin
        d = decode(p);
        if (d < 0) m_se = 1;
        else begin
          m_digit = 4'(d);
          m_dv = 1;
          m_locked = 1;
          m_count = m_count + 8'd1;
`ifdef SEVEN_SEG_FIB_CHECK_EN
          m_fe = m_fib != (d inside {0, 1, 2, 3, 5, 8, 13});
`endif
        end
      end
    end
    exp_vec = {m_digit, m_dv, m_locked, m_se, m_count, m_fe};
    vecs++;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(7'($urandom), 1'($urandom), 1'b0);
      if (out_vec !== exp_vec || out_vec !== 16'h0) begin
        fails++;
        $display("FAIL reset: got %h exp %h", out_vec, exp_vec);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(7'h7F, 1'b0, 1'b1);
      if (out_vec !== exp_vec) begin
        fails++;
        $display("FAIL reset_blank: got %h exp %h", out_vec, exp_vec);
      end
    end
  endtask
  task automatic test_digit();
    for (int i = 0; i < 6; i++) begin
      step(7'h12, 1'b1, 1'b1);
      if (out_vec !== exp_vec) begin
        fails++;
        $display("FAIL digit5 cyc%0d: got %h exp %h", i, out_vec, exp_vec);
      end
    end
  endtask
  task automatic test_glitch();
    logic [6:0] seq [12] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h12, 7'h79,
                             7'h12, 7'h12, 7'h12, 7'h12, 7'h12};
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(seq[i], 1'b1, 1'b1);
      pulses += int'(digit_valid);
      if (out_vec !== exp_vec) begin
        fails++;
        $display("FAIL glitch cyc%0d: got %h exp %h", i, out_vec, exp_vec);
      end
    end
    vecs++;
    if (pulses != 1 || digit !== 4'h5) begin
      fails++;
      $display("FAIL glitch_pulses: got %0d pulses digit %h exp 1 pulse digit 5", pulses, digit);
    end
  endtask
  task automatic test_illegal();
    for (int i = 0; i < 6; i++) begin
      step(7'h7E, 1'b0, 1'b1);
      if (out_vec !== exp_vec) begin
        fails++;
        $display("FAIL illegal cyc%0d: got %h exp %h", i, out_vec, exp_vec);
      end
    end
  endtask
  task automatic test_fib();
    int ds [3] = '{4, 8, 13};
    logic fs [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 5; i++) begin
        step(bus_of(ds[k]), fs[k], 1'b1);
        if (out_vec !== exp_vec) begin
          fails++;
          $display("FAIL fib d%0d cyc%0d: got %h exp %h", ds[k], i, out_vec, exp_vec);
        end
      end
  endtask
  task automatic test_random();
    logic [6:0] b;
    logic f;
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 5))
        0: b = 7'h7F;
        1: b = 7'($urandom);
        default: b = bus_of(int'($urandom_range(0, 15)));
      endcase
      f = 1'($urandom);
      for (int i = 0, h = int'($urandom_range(1, 6)); i < h; i++) begin
        step(b, f, ($urandom_range(0, 40) != 0));
        if (out_vec !== exp_vec) begin
          fails++;
          $display("FAIL random n%0d: got %h exp %h", n, out_vec, exp_vec);
        end
      end
    end
  endtask
  task automatic test_wrap();
    step(7'h7F, 1'b0, 1'b0);
    for (int n = 0; n < 256; n++)
      for (int i = 0; i < S; i++) begin
        step(bus_of(n % 2), 1'b1, 1'b1);
        if (out_vec !== exp_vec) begin
          fails++;
          $display("FAIL wrap n%0d: got %h exp %h", n, out_vec, exp_vec);
        end
      end
    vecs++;
    if (digit_count !== 8'd0) begin
      fails++;
      $display("FAIL wrap_count: got %0d exp 0", digit_count);
    end
  endtask
  task automatic test_reset_mid_settle();
    step(bus_of(2), 1'b1, 1'b1);
    step(bus_of(2), 1'b1, 1'b1);
    step(bus_of(2), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(bus_of(2), 1'b1, i > 0);
      if (out_vec !== exp_vec || (i < 3 && out_vec !== 16'h0)) begin
        fails++;
        $display("FAIL reset_mid cyc%0d: got %h exp %h", i, out_vec, exp_vec);
      end
    end
  endtask
  initial begin
    test_reset();
    test_digit();
    test_glitch();
    test_illegal();
    test_fib();
    test_random();
    test_wrap();
    test_reset_mid_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
